// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader: FSM state encoding, memory
// depth and the bit positions of the count fields in the stream header word.
// ---------------------------------------------------------------------------
package program_loader_pkg;

    // Depth of both the instruction and the data memory, in words.
    localparam int MEM_DEPTH = 2048;

    // Header word layout: im_count sits in [27:16], dm_count in [11:0].
    localparam int IM_CNT_LSB = 16;
    localparam int DM_CNT_LSB = 0;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_IM_WR,
        ST_DM_WR,
        ST_CHECK,
        ST_DRAIN,
        ST_RUN,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Host word stream into the program loader (valid/ready handshake).
//   in_data  : stream word, driven by the host
//   in_valid : in_data is valid, driven by the host
//   in_ready : loader takes the word on this edge, driven by the loader
// Modports: master = host side, slave = loader side.
// ---------------------------------------------------------------------------
interface program_loader_if #(
    parameter int DATA_WIDTH = 32
);
    import program_loader_pkg::*;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/program_loader_write_port.sv
// ---------------------------------------------------------------------------
// loader_write_port
// Registered write-strobe driver for one single-port memory. Every cycle
// with wr_en_i high produces a one-cycle strobe (cen=0, wen=0) in the next
// cycle, carrying the registered data and the current write address; the
// address then advances by one. Outside strobes cen/wen stay high while
// address and data hold their last values. oen is always high (no reads).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear_i        : reset the write-address counter to 0
//   wr_en_i        : issue one write of data_i
//   data_i         : word to write
//   cen_o, wen_o, oen_o : active-low memory strobes
//   addr_o, data_o : registered memory address and write data
// ---------------------------------------------------------------------------
module loader_write_port
    import program_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic                     cen_o,
    output logic                     wen_o,
    output logic                     oen_o,
    output logic [ADDRESS_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0]    data_o
);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] next_addr_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     cen_q;
    logic                     wen_q;

    // next_addr_q wraps to 0 after a full-depth section, but addr_q keeps
    // the last written address, so the pins never show the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_addr_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cen_q       <= 1'b1;
            wen_q       <= 1'b1;
        end else begin
            cen_q <= ~wr_en_i;
            wen_q <= ~wr_en_i;
            if (wr_en_i) begin
                addr_q      <= next_addr_q;
                data_q      <= data_i;
                next_addr_q <= next_addr_q + ADDR_ONE;
            end else if (clear_i) begin
                next_addr_q <= '0;
            end
        end
    end

    assign cen_o  = cen_q;
    assign wen_o  = wen_q;
    assign oen_o  = 1'b1;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Preload controller in front of the processor. Takes a header word
// (im_count in [27:16], dm_count in [11:0]), then im_count instruction
// words and dm_count data words, writing them to IM/DM addresses from 0.
// The core is held in reset (loading=1, proc_rst_n=0) until the load has
// finished; a reload pulse while running starts a new load.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN: a trailer word follows
// the payload and must equal the XOR of header and payload words,
// otherwise the loader enters the sticky error state.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   host            : host word stream (program_loader_if.slave)
//   reload_i        : one-cycle pulse, restarts loading from RUN
//   loading_o       : processor loading flag
//   proc_rst_n_o    : processor active-low reset
//   im_*_load_o     : instruction-memory strobes, address, write data
//   dm_*_load_o     : data-memory strobes, address, write data
//   done_o          : load complete and core running
//   error_o         : sticky header-count or checksum fault
// ---------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32,
    parameter int COUNT_WIDTH   = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    program_loader_if.slave          host,
    input  logic                     reload_i,
    output logic                     loading_o,
    output logic                     proc_rst_n_o,
    output logic                     im_cen_load_o,
    output logic                     im_wen_load_o,
    output logic                     im_oen_load_o,
    output logic [ADDRESS_WIDTH-1:0] im_addr_load_o,
    output logic [DATA_WIDTH-1:0]    im_datain_load_o,
    output logic                     dm_cen_load_o,
    output logic                     dm_wen_load_o,
    output logic                     dm_oen_load_o,
    output logic [ADDRESS_WIDTH-1:0] dm_addr_load_o,
    output logic [DATA_WIDTH-1:0]    dm_datain_load_o,
    output logic                     done_o,
    output logic                     error_o
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MEM_DEPTH);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_PAYLOAD = ST_CHECK;
`else
    localparam state_t ST_AFTER_PAYLOAD = ST_DRAIN;
`endif

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] im_cnt_q, im_cnt_d;
    logic [COUNT_WIDTH-1:0] dm_cnt_q, dm_cnt_d;
    logic [COUNT_WIDTH-1:0] idx_q, idx_d;
    logic                   in_ready_q, in_ready_d;
    logic                   loading_q, proc_rst_n_q, done_q, error_q;
    logic                   run_stable;
    logic                   accept;
    logic                   im_wr, dm_wr, clear_addr;
    logic [COUNT_WIDTH-1:0] hdr_im, hdr_dm;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  csum_q, csum_d;
`endif

    // in_ready is registered, so it already reflects the current state.
    assign accept = host.in_valid && in_ready_q;
    assign hdr_im = host.in_data[IM_CNT_LSB +: COUNT_WIDTH];
    assign hdr_dm = host.in_data[DM_CNT_LSB +: COUNT_WIDTH];

    always_comb begin
        state_d    = state_q;
        im_cnt_d   = im_cnt_q;
        dm_cnt_d   = dm_cnt_q;
        idx_d      = idx_q;
        im_wr      = 1'b0;
        dm_wr      = 1'b0;
        clear_addr = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_HEADER: begin
                if (accept) begin
                    im_cnt_d = hdr_im;
                    dm_cnt_d = hdr_dm;
                    idx_d    = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d   = host.in_data;
`endif
                    if (hdr_im > MAX_COUNT || hdr_dm > MAX_COUNT) begin
                        state_d = ST_ERROR;
                    end else if (hdr_im != '0) begin
                        state_d = ST_IM_WR;
                    end else if (hdr_dm != '0) begin
                        state_d = ST_DM_WR;
                    end else begin
                        state_d = ST_AFTER_PAYLOAD;
                    end
                end
            end
            ST_IM_WR: begin
                if (accept) begin
                    im_wr = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ host.in_data;
`endif
                    if ((idx_q + CNT_ONE) == im_cnt_q) begin
                        idx_d   = '0;
                        state_d = (dm_cnt_q != '0) ? ST_DM_WR : ST_AFTER_PAYLOAD;
                    end else begin
                        idx_d = idx_q + CNT_ONE;
                    end
                end
            end
            ST_DM_WR: begin
                if (accept) begin
                    dm_wr = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ host.in_data;
`endif
                    if ((idx_q + CNT_ONE) == dm_cnt_q) begin
                        idx_d   = '0;
                        state_d = ST_AFTER_PAYLOAD;
                    end else begin
                        idx_d = idx_q + CNT_ONE;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    state_d = (host.in_data == csum_q) ? ST_DRAIN : ST_ERROR;
                end
            end
`endif
            ST_DRAIN: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (reload_i) begin
                    state_d    = ST_HEADER;
                    clear_addr = 1'b1;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    assign in_ready_d = (state_d == ST_HEADER) || (state_d == ST_IM_WR) ||
                        (state_d == ST_DM_WR)  || (state_d == ST_CHECK);

    // The core is released one cycle after RUN is entered, but the status
    // drops on the very edge that leaves RUN.
    assign run_stable = (state_q == ST_RUN) && (state_d == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HEADER;
            im_cnt_q     <= '0;
            dm_cnt_q     <= '0;
            idx_q        <= '0;
            in_ready_q   <= 1'b0;
            loading_q    <= 1'b1;
            proc_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            im_cnt_q     <= im_cnt_d;
            dm_cnt_q     <= dm_cnt_d;
            idx_q        <= idx_d;
            in_ready_q   <= in_ready_d;
            loading_q    <= ~run_stable;
            proc_rst_n_q <= run_stable;
            done_q       <= run_stable;
            error_q      <= error_q | (state_d == ST_ERROR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign host.in_ready = in_ready_q;
    assign loading_o     = loading_q;
    assign proc_rst_n_o  = proc_rst_n_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

    loader_write_port #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_im_port (
        .clk    (clk),
        .rst    (rst),
        .clear_i(clear_addr),
        .wr_en_i(im_wr),
        .data_i (host.in_data),
        .cen_o  (im_cen_load_o),
        .wen_o  (im_wen_load_o),
        .oen_o  (im_oen_load_o),
        .addr_o (im_addr_load_o),
        .data_o (im_datain_load_o)
    );

    loader_write_port #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_dm_port (
        .clk    (clk),
        .rst    (rst),
        .clear_i(clear_addr),
        .wr_en_i(dm_wr),
        .data_i (host.in_data),
        .cen_o  (dm_cen_load_o),
        .wen_o  (dm_wen_load_o),
        .oen_o  (dm_oen_load_o),
        .addr_o (dm_addr_load_o),
        .data_o (dm_datain_load_o)
    );

endmodule

// File: doc/program_loader.md
# program_loader

Host-facing preload controller that sits directly upstream of the processor top. It accepts a 32-bit word stream and drives the processor's `loading` signal and the `im_*_load` / `dm_*_load` ports, filling instruction memory and then data memory. It holds the core in reset while loading, then releases it.

## Interface
- `ADDRESS_WIDTH`, default 11: memory word-address width (depth 2048).
- `DATA_WIDTH`, default 32: stream and memory word width.
- `COUNT_WIDTH`, default 12: header count field width; counts run 0..2048.

Ports:
- `clk` in 1: single clock, shared with the processor.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in DATA_WIDTH: host stream word.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts the word on this edge.
- `reload` in 1: single-cycle pulse; restarts loading from RUN.
- `loading` out 1: to processor `loading`.
- `proc_rst_n` out 1: to processor `rst_n`; low holds the core in reset.
- `im_cen_load`, `im_wen_load`, `im_oen_load` out 1 each: active-low IM strobes.
- `im_addr_load` out ADDRESS_WIDTH; `im_datain_load` out DATA_WIDTH.
- `dm_cen_load`, `dm_wen_load`, `dm_oen_load`, `dm_addr_load`, `dm_datain_load`: same as the IM set, for data memory.
- `done` out 1: load complete and core running.
- `error` out 1: sticky header or checksum fault.

## Operation
- A transfer is accepted when `in_valid && in_ready`.
- Stream format, in order:
  - Header word: bits [27:16] = `im_count`, bits [11:0] = `dm_count`. Bits [31:28] and [15:12] are ignored.
  - `im_count` IM payload words, written to addresses 0..`im_count`-1.
  - `dm_count` DM payload words, written to addresses 0..`dm_count`-1.
- States:
  - HEADER: `in_ready`=1. On accept:
    - any count > 2048 → ERROR;
    - else if `im_count`≠0 → IM_WR;
    - else if `dm_count`≠0 → DM_WR;
    - else → DRAIN.
  - IM_WR: `in_ready`=1. Each accept issues one IM write and increments the address. The accept of word `im_count`-1 moves to DM_WR if `dm_count`≠0, else to DRAIN.
  - DM_WR: same as IM_WR, targeting DM. The last accept moves to DRAIN.
  - DRAIN: one cycle, `in_ready`=0, lets the final write strobe complete. Then → RUN.
  - RUN: `loading`=0, `proc_rst_n`=1, `done`=1, `in_ready`=0. A `reload` pulse → HEADER.
  - ERROR: `in_ready`=0, `error`=1, `loading`=1, `proc_rst_n`=0. Left only by `rst`.
- Write strobe, one cycle per accepted word:
  - `cen`=0, `wen`=0, `oen`=1;
  - address and data come from registers.
  - In all other cycles `cen`/`wen`/`oen`=1, while address and data hold their last values.
- `loading`=1 and `proc_rst_n`=0 in every state except RUN.
- Entering HEADER from RUN sets `loading`=1, `proc_rst_n`=0 and `done`=0 on the same edge, and clears both address counters.
- Address counters are ADDRESS_WIDTH wide. A count of exactly 2048 ends at address 2047 and does not wrap. The count-vs-index compare uses COUNT_WIDTH.

## Timing
- Reset values:
  - `loading`=1, `proc_rst_n`=0;
  - all `cen`/`wen`/`oen`=1;
  - addresses and data = 0;
  - `in_ready`=0, `done`=0, `error`=0.
  - State = HEADER; `in_ready` rises in the first cycle after `rst` deasserts.
- All outputs are registered; no combinational path from `in_*` to any output.
- Latency: a word accepted at edge N appears on the memory pins during cycle N+1. The RAM samples it at edge N+1.
- Throughput: one word per cycle. `in_valid` gaps insert idle (`cen`=1) cycles.
- The last payload accept at edge N gives: DRAIN during N+1, and `loading`=0, `proc_rst_n`=1, `done`=1 from edge N+2.
- `reload` outside RUN is ignored. `rst` mid-load aborts immediately to reset values; a partially written memory is not cleared.

## Configuration
- Macro `PROGRAM_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last payload word (or after the header if both counts are 0), state CHECK accepts one trailer word.
  - The trailer is compared with the XOR of the header and all payload words.
  - Match → DRAIN; mismatch → ERROR. The DRAIN-then-RUN sequence still completes.
- Undefined: no trailer and no CHECK state; the last payload goes straight to DRAIN.

## Structure
- Package `program_loader_pkg`:
  - state enum (HEADER, IM_WR, DM_WR, CHECK, DRAIN, RUN, ERROR);
  - `MEM_DEPTH`=2048;
  - header field bit positions.
- Sub-module `loader_write_port`: a registered cen/wen/oen/addr/data driver with a `wr_en` and data input. It is instantiated twice, once for IM and once for DM.

## Test plan
- Header 0x0003_0002, then IM words 0xA0..0xA2 and DM words 0xB0..0xB1 → IM[0..2]=A0..A2 and DM[0..1]=B0..B1. `done`=1 exactly 2 cycles after the last accept.
- Header 0x0801_0000 (im_count=2049) → `error`=1 next cycle, `in_ready`=0, `loading` stays 1.
- Header 0x0000_0000 → DRAIN, then RUN, with no write strobes.
- `in_valid` toggled 1-0-1 during IM_WR → idle cycle with `cen`=1, and addresses remain contiguous.
- `rst` asserted after 2 of 5 IM words → all outputs at reset values next cycle. A fresh header is then accepted.
- With `PROGRAM_LOADER_CHECKSUM_EN`, header 0x0001_0000 + word 0x5 + trailer 0x0001_0005 → RUN; trailer 0x0 → ERROR.
